// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
//   arb_state_t : arbiter FSM states (one transaction outstanding at a time)
//   IF_BE_ALL   : byte enables presented to memory for an instruction fetch
//   is_busy()   : true while a memory transaction is outstanding
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_MA = 2'd2
    } arb_state_t;

    localparam logic [3:0] IF_BE_ALL = 4'hF;

    function automatic logic is_busy(input arb_state_t state);
        return (state != IDLE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch (IF), load/store (MA) and memory-side signals around
// the memory port arbiter.
//   master : the arbiter's view (takes pipeline requests and memory
//            responses, drives the memory request and the pipeline results)
//   slave  : the surrounding pipeline/memory view (mirror of master)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch side
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;
    // load/store side
    logic              ma_req;
    logic              ma_we;
    logic [ADDR_W-1:0] ma_addr;
    logic [DATA_W-1:0] ma_wdata;
    logic [3:0]        ma_be;
    logic [DATA_W-1:0] ma_rdata;
    logic              ma_valid;
    logic              ma_stall;
    // memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr, if_flush,
        input  ma_req, ma_we, ma_addr, ma_wdata, ma_be,
        input  mem_ready, mem_rdata,
        output if_rdata, if_valid, if_stall,
        output ma_rdata, ma_valid, ma_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output if_req, if_addr, if_flush,
        output ma_req, ma_we, ma_addr, ma_wdata, ma_be,
        output mem_ready, mem_rdata,
        input  if_rdata, if_valid, if_stall,
        input  ma_rdata, ma_valid, ma_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/mem_arb_fair_cnt.sv
// Starvation counter: counts consecutive MA grants made while a fetch is
// waiting, saturating at MA_RUN_MAX, and is cleared whenever IF is granted.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : an MA grant happened while IF was requesting
//   clr        : an IF grant happened
//   at_max     : counter has reached MA_RUN_MAX (IF now takes priority)
module mem_arb_fair_cnt #(
    parameter int MA_RUN_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CNT_W = $clog2(MA_RUN_MAX + 1);

    logic [CNT_W-1:0] cnt_r;

    assign at_max = (cnt_r == CNT_W'(MA_RUN_MAX));

    // Run counter: clear has precedence, increment stops at the maximum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && !at_max) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port unified memory between the fetch stage (IF) and the
// load/store stage (MA). MA normally wins; after MA_RUN_MAX consecutive MA
// grants with a fetch waiting, IF wins the next IDLE arbitration. On
// completion the other requester is granted back-to-back.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : IF/MA request and result signals plus the memory port
//                (mem_* registered at grant and held until mem_ready;
//                 *_valid and *_rdata combinational from mem_ready/mem_rdata)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MA_RUN_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.master   bus
);

    arb_state_t        state_r;
    arb_state_t        state_next_s;
    logic              grant_if_s;
    logic              grant_ma_s;
    logic              run_inc_s;
    logic              run_at_max_s;
    logic              done_s;
    logic              if_want_s;
    logic              drop_r;

    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [3:0]        mem_be_r;

    logic              if_valid_s;
    logic              ma_valid_s;
    logic [DATA_W-1:0] if_rdata_s;
    logic [DATA_W-1:0] ma_rdata_s;

    // mem_ready is meaningless while no access is outstanding.
    assign done_s    = is_busy(state_r) && bus.mem_ready;
    // A flush in the same cycle kills the fetch request before arbitration.
    assign if_want_s = bus.if_req && !bus.if_flush;

    // Arbitration and next-state selection.
    always_comb begin
        state_next_s = state_r;
        grant_if_s   = 1'b0;
        grant_ma_s   = 1'b0;
        run_inc_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (if_want_s && (!bus.ma_req || run_at_max_s)) begin
                    grant_if_s   = 1'b1;
                    state_next_s = BUSY_IF;
                end else if (bus.ma_req) begin
                    grant_ma_s   = 1'b1;
                    run_inc_s    = bus.if_req;
                    state_next_s = BUSY_MA;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY_IF: begin
                // The fetch that just finished is not a waiting fetch, so
                // this back-to-back MA grant does not count toward the run.
                if (done_s) begin
                    if (bus.ma_req) begin
                        grant_ma_s   = 1'b1;
                        state_next_s = BUSY_MA;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = BUSY_IF;
                end
            end
            BUSY_MA: begin
                if (done_s) begin
                    if (if_want_s) begin
                        grant_if_s   = 1'b1;
                        state_next_s = BUSY_IF;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = BUSY_MA;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    mem_arb_fair_cnt #(
        .MA_RUN_MAX (MA_RUN_MAX)
    ) u_fair_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (grant_ma_s && run_inc_s),
        .clr    (grant_if_s),
        .at_max (run_at_max_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Memory request registers: capture the winner's fields at grant time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_be_r    <= 4'h0;
        end else begin
            mem_req_r <= is_busy(state_next_s);
            if (grant_if_s) begin
                mem_we_r    <= 1'b0;
                mem_addr_r  <= bus.if_addr;
                mem_wdata_r <= {DATA_W{1'b0}};
                mem_be_r    <= IF_BE_ALL;
            end else if (grant_ma_s) begin
                mem_we_r    <= bus.ma_we;
                mem_addr_r  <= bus.ma_addr;
                mem_wdata_r <= bus.ma_wdata;
                mem_be_r    <= bus.ma_be;
            end else begin
                mem_we_r    <= mem_we_r;
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
                mem_be_r    <= mem_be_r;
            end
        end
    end

    // Drop flag: a flushed fetch still finishes on memory but is not
    // delivered; the flag lives exactly as long as that fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_r <= 1'b0;
        end else if (grant_if_s) begin
            drop_r <= 1'b0;
        end else if ((state_r == BUSY_IF) && done_s) begin
            drop_r <= 1'b0;
        end else if ((state_r == BUSY_IF) && bus.if_flush) begin
            drop_r <= 1'b1;
        end else begin
            drop_r <= drop_r;
        end
    end

    // Completion steering: only the owner of the access sees valid/rdata.
    always_comb begin
        if_valid_s = 1'b0;
        ma_valid_s = 1'b0;
        if_rdata_s = {DATA_W{1'b0}};
        ma_rdata_s = {DATA_W{1'b0}};
        if ((state_r == BUSY_IF) && bus.mem_ready && !drop_r && !bus.if_flush) begin
            if_valid_s = 1'b1;
            if_rdata_s = bus.mem_rdata;
        end else if ((state_r == BUSY_MA) && bus.mem_ready) begin
            ma_valid_s = 1'b1;
            // Stores complete on mem_ready but carry no read data.
            if (!mem_we_r) begin
                ma_rdata_s = bus.mem_rdata;
            end else begin
                ma_rdata_s = {DATA_W{1'b0}};
            end
        end else begin
            if_valid_s = 1'b0;
            ma_valid_s = 1'b0;
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_be    = mem_be_r;
    assign bus.if_valid  = if_valid_s;
    assign bus.if_rdata  = if_rdata_s;
    assign bus.if_stall  = bus.if_req && !if_valid_s;
    assign bus.ma_valid  = ma_valid_s;
    assign bus.ma_rdata  = ma_rdata_s;
    assign bus.ma_stall  = bus.ma_req && !ma_valid_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized pipeline/memory traffic, all compared cycle by cycle against a
// transaction-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int RUN_MAX = 4;

    logic clk;
    logic reset;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MA_RUN_MAX (RUN_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // reference model: owner 0 = none, 1 = fetch, 2 = load/store
    int          m_owner;
    bit          m_drop;
    int          m_run;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    bit          e_if_valid;
    bit          e_ma_valid;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_owner = 0; m_drop = 1'b0; m_run = 0;
        m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_be = 4'h0;
    endtask

    task automatic give_if();
        m_owner = 1; m_run = 0; m_drop = 1'b0;
        m_we = 1'b0; m_addr = bus_if.if_addr; m_wdata = 32'h0; m_be = 4'hF;
    endtask

    task automatic give_ma(input bit fetch_waiting);
        m_owner = 2;
        if (fetch_waiting && m_run < RUN_MAX) m_run = m_run + 1;
        m_we = bus_if.ma_we; m_addr = bus_if.ma_addr;
        m_wdata = bus_if.ma_wdata; m_be = bus_if.ma_be;
    endtask

    // Wait for inputs to settle mid-cycle, then compare every output.
    task automatic settle_check();
        logic [31:0] e_if_rdata;
        logic [31:0] e_ma_rdata;
        #3;
        e_if_valid = (m_owner == 1) && bus_if.mem_ready && !m_drop && !bus_if.if_flush;
        e_ma_valid = (m_owner == 2) && bus_if.mem_ready;
        e_if_rdata = e_if_valid ? bus_if.mem_rdata : 32'h0;
        e_ma_rdata = (e_ma_valid && !m_we) ? bus_if.mem_rdata : 32'h0;
        check_eq("mem_req",   32'(bus_if.mem_req), 32'(m_owner != 0));
        check_eq("mem_we",    32'(bus_if.mem_we),  32'(m_we));
        check_eq("mem_addr",  bus_if.mem_addr,     m_addr);
        check_eq("mem_wdata", bus_if.mem_wdata,    m_wdata);
        check_eq("mem_be",    32'(bus_if.mem_be),  32'(m_be));
        check_eq("if_valid",  32'(bus_if.if_valid), 32'(e_if_valid));
        check_eq("if_rdata",  bus_if.if_rdata,     e_if_rdata);
        check_eq("ma_valid",  32'(bus_if.ma_valid), 32'(e_ma_valid));
        check_eq("ma_rdata",  bus_if.ma_rdata,     e_ma_rdata);
        check_eq("if_stall",  32'(bus_if.if_stall), 32'(bus_if.if_req && !e_if_valid));
        check_eq("ma_stall",  32'(bus_if.ma_stall), 32'(bus_if.ma_req && !e_ma_valid));
        check_eq("run_cnt",   32'(dut.u_fair_cnt.cnt_r), 32'(m_run));
    endtask

    // Apply the arbitration rules to this cycle's inputs, then move to the
    // next cycle (inputs are driven 1 time unit after the rising edge).
    task automatic advance();
        bit done;
        bit want_if;
        if (reset) begin
            m_reset();
        end else begin
            done    = (m_owner != 0) && bus_if.mem_ready;
            want_if = bus_if.if_req && !bus_if.if_flush;
            if (m_owner == 0) begin
                if (want_if && (!bus_if.ma_req || m_run == RUN_MAX)) give_if();
                else if (bus_if.ma_req) give_ma(bus_if.if_req);
            end else if (m_owner == 1) begin
                if (done) begin
                    m_drop = 1'b0;
                    if (bus_if.ma_req) give_ma(1'b0);
                    else m_owner = 0;
                end else if (bus_if.if_flush) begin
                    m_drop = 1'b1;
                end
            end else begin
                if (done) begin
                    if (want_if) give_if();
                    else m_owner = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus_if.if_req = 1'b0; bus_if.if_flush = 1'b0; bus_if.ma_req = 1'b0;
        bus_if.mem_ready = 1'b1;
        repeat (3) begin settle_check(); advance(); end
        bus_if.mem_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus_if.if_req = 1'b0; bus_if.if_addr = 32'h0; bus_if.if_flush = 1'b0;
        bus_if.ma_req = 1'b0; bus_if.ma_we = 1'b0; bus_if.ma_addr = 32'h0;
        bus_if.ma_wdata = 32'h0; bus_if.ma_be = 4'h0;
        bus_if.mem_ready = 1'b1; bus_if.mem_rdata = 32'h12345678;
        m_reset();
        @(posedge clk); #1;
        settle_check();                               // reset state
        check_eq("reset_mem_req", 32'(bus_if.mem_req), 32'h0);
        advance();
        reset = 1'b0;
        bus_if.mem_ready = 1'b0;

        // fetch only
        bus_if.if_req = 1'b1; bus_if.if_addr = 32'h100;
        settle_check(); advance();
        bus_if.mem_ready = 1'b1; bus_if.mem_rdata = 32'h00500093;
        settle_check();
        check_eq("t1_addr",  bus_if.mem_addr, 32'h100);
        check_eq("t1_be",    32'(bus_if.mem_be), 32'hF);
        check_eq("t1_valid", 32'(bus_if.if_valid), 32'h1);
        check_eq("t1_rdata", bus_if.if_rdata, 32'h00500093);
        advance();
        bus_if.if_req = 1'b0; bus_if.mem_ready = 1'b0;
        settle_check();
        check_eq("t1_pulse", 32'(bus_if.if_valid), 32'h0);
        advance();

        // simultaneous requests: MA first, then IF back-to-back
        bus_if.if_req = 1'b1; bus_if.if_addr = 32'h104;
        bus_if.ma_req = 1'b1; bus_if.ma_we = 1'b0; bus_if.ma_addr = 32'h80; bus_if.ma_be = 4'hF;
        settle_check(); advance();
        check_eq("t2_ma_first", bus_if.mem_addr, 32'h80);
        check_eq("t2_if_stall", 32'(bus_if.if_stall), 32'h1);
        bus_if.mem_ready = 1'b1; bus_if.mem_rdata = 32'h11223344;
        settle_check();
        check_eq("t2_ma_rdata", bus_if.ma_rdata, 32'h11223344);
        advance();
        bus_if.ma_req = 1'b0; bus_if.mem_ready = 1'b0;
        settle_check();
        check_eq("t2_b2b_req",  32'(bus_if.mem_req), 32'h1);
        check_eq("t2_b2b_addr", bus_if.mem_addr, 32'h104);
        advance();
        quiet();

        // starvation: fetch kept out by flush until MA has run RUN_MAX times
        bus_if.if_req = 1'b1; bus_if.if_addr = 32'h300; bus_if.if_flush = 1'b1;
        bus_if.ma_req = 1'b1; bus_if.ma_addr = 32'h40;
        for (int g = 0; g < RUN_MAX; g++) begin
            bus_if.mem_ready = 1'b0; settle_check(); advance();
            bus_if.mem_ready = 1'b1; settle_check(); advance();
        end
        check_eq("t3_run_sat", 32'(dut.u_fair_cnt.cnt_r), 32'(RUN_MAX));
        bus_if.if_flush = 1'b0; bus_if.mem_ready = 1'b0;
        settle_check(); advance();
        check_eq("t3_if_wins", bus_if.mem_addr, 32'h300);
        check_eq("t3_run_clr", 32'(dut.u_fair_cnt.cnt_r), 32'h0);
        quiet();

        // store
        bus_if.ma_req = 1'b1; bus_if.ma_we = 1'b1; bus_if.ma_addr = 32'h2004;
        bus_if.ma_wdata = 32'hDEADBEEF; bus_if.ma_be = 4'b0011;
        settle_check(); advance();
        bus_if.mem_ready = 1'b1; bus_if.mem_rdata = 32'hCAFEF00D;
        settle_check();
        check_eq("t4_we",    32'(bus_if.mem_we), 32'h1);
        check_eq("t4_addr",  bus_if.mem_addr, 32'h2004);
        check_eq("t4_wdata", bus_if.mem_wdata, 32'hDEADBEEF);
        check_eq("t4_be",    32'(bus_if.mem_be), 32'h3);
        check_eq("t4_valid", 32'(bus_if.ma_valid), 32'h1);
        advance();
        quiet();

        // flush during a fetch, then a fresh fetch
        bus_if.if_req = 1'b1; bus_if.if_addr = 32'h180;
        settle_check(); advance();
        bus_if.if_flush = 1'b1;
        settle_check(); advance();
        bus_if.if_flush = 1'b0; bus_if.if_addr = 32'h200;
        for (int k = 0; k < 3; k++) begin
            bus_if.mem_ready = (k == 2) ? 1'b1 : 1'b0;
            settle_check();
            check_eq("t5_no_valid", 32'(bus_if.if_valid), 32'h0);
            advance();
        end
        bus_if.mem_ready = 1'b0;
        settle_check(); advance();
        bus_if.mem_ready = 1'b1; bus_if.mem_rdata = 32'h00A00113;
        settle_check();
        check_eq("t5_new_addr", bus_if.mem_addr, 32'h200);
        check_eq("t5_valid",    32'(bus_if.if_valid), 32'h1);
        check_eq("t5_rdata",    bus_if.if_rdata, 32'h00A00113);
        advance();
        quiet();

        // reset in the middle of an MA access
        bus_if.ma_req = 1'b1; bus_if.ma_we = 1'b0; bus_if.ma_addr = 32'h44;
        settle_check(); advance();
        bus_if.mem_ready = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        check_eq("t6_req_drop",   32'(bus_if.mem_req), 32'h0);
        check_eq("t6_valid_drop", 32'(bus_if.ma_valid), 32'h0);
        m_reset();
        bus_if.ma_req = 1'b0; bus_if.mem_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        settle_check();
        check_eq("t6_idle_run", 32'(dut.u_fair_cnt.cnt_r), 32'h0);
        advance();

        // randomized traffic, light then heavy flushing
        for (int phase = 0; phase < 2; phase++) begin
            for (int c = 0; c < 1500; c++) begin
                if (bus_if.ma_req && e_ma_valid) bus_if.ma_req = 1'b0;
                if (!bus_if.ma_req && ($urandom % 3 == 0)) begin
                    bus_if.ma_req   = 1'b1;
                    bus_if.ma_we    = 1'($urandom % 2);
                    bus_if.ma_addr  = $urandom & 32'hFFFF_FFFC;
                    bus_if.ma_wdata = $urandom;
                    bus_if.ma_be    = 4'($urandom);
                end
                if (bus_if.if_req && (e_if_valid || bus_if.if_flush)) bus_if.if_req = 1'b0;
                if (!bus_if.if_req && ($urandom % 2 == 0)) begin
                    bus_if.if_req  = 1'b1;
                    bus_if.if_addr = $urandom & 32'hFFFF_FFFC;
                end
                bus_if.if_flush  = bus_if.if_req && ($urandom % ((phase == 0) ? 8 : 2) == 0);
                bus_if.mem_ready = 1'($urandom % 2);
                bus_if.mem_rdata = $urandom;
                settle_check();
                advance();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
